// File: rtl/wght_bias_update.sv
// Live weight/bias store for the 2-3-2 MLP: counts samples, then applies
// saturating w <= w - delta one element per cycle and clears the accumulators.
module wbu_elem #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (rst)       r_q <= '0;
    else if (i_we) r_q <= i_wdata;
  end

  assign o_q = r_q;
endmodule

module wght_bias_update #(
  parameter int N_IN   = 2,
  parameter int N_HL_P = 3,
  parameter int N_OUT  = 2,
  parameter int WIDTH  = 32,
  parameter int BATCH  = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_smpl_vld,
  input  logic                            i_flush,
  input  logic                            i_ld_en,
  input  logic [4:0]                      i_ld_addr,
  input  logic [WIDTH-1:0]                i_ld_data,
  input  logic [N_OUT*WIDTH-1:0]          i_dbias_o,
  input  logic [N_HL_P*WIDTH-1:0]         i_dbias_hd,
  input  logic [N_HL_P*N_OUT*WIDTH-1:0]   i_dwght_o,
  input  logic [N_HL_P*N_IN*WIDTH-1:0]    i_dwght_hd,
  output logic                            o_acc_en,
  output logic                            o_acc_rst,
  output logic                            o_ready,
  output logic                            o_done,
  output logic                            o_drop,
  output logic [N_OUT*WIDTH-1:0]          o_bias_o,
  output logic [N_HL_P*WIDTH-1:0]         o_bias_hd,
  output logic [N_HL_P*N_OUT*WIDTH-1:0]   o_wght_o,
  output logic [N_HL_P*N_IN*WIDTH-1:0]    o_wght_hd
);
  localparam int N_BO  = N_OUT;
  localparam int N_BH  = N_HL_P;
  localparam int N_WO  = N_HL_P * N_OUT;
  localparam int N_WH  = N_HL_P * N_IN;
  localparam int N_TOT = N_BO + N_BH + N_WO + N_WH;
  localparam int IW    = $clog2(N_TOT);
  localparam int CW    = (BATCH > 1) ? $clog2(BATCH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_UPD, S_CLR} state_t;

  state_t                        r_state, w_state_nxt;
  logic [CW-1:0]                 r_cnt;
  logic [IW-1:0]                 r_idx;
  logic                          r_drop;
  logic [N_TOT-1:0][WIDTH-1:0]   w_elem;
  logic [N_TOT-1:0][WIDTH-1:0]   w_delta;
  logic [WIDTH-1:0]              w_cur;
  logic [WIDTH-1:0]              w_dsel;
  logic [WIDTH:0]                w_diff;
  logic [WIDTH-1:0]              w_sat;
  logic                          w_idle;
  logic                          w_last;
  logic                          w_fl;
  logic                          w_go;
  logic                          w_upd;
  logic                          w_ld;

  assign w_delta = {i_dwght_hd, i_dwght_o, i_dbias_hd, i_dbias_o};

  assign w_idle = (r_state == S_IDLE);
  assign w_upd  = (r_state == S_UPD);
  assign w_last = i_smpl_vld && (r_cnt == CW'(BATCH - 1));
  // A flush that coincides with the batch-closing sample folds into one update.
  assign w_fl   = i_flush && (r_cnt != '0) && !w_last;
  assign w_go   = w_idle && (w_last || w_fl);
  assign w_ld   = w_idle && i_ld_en && (i_ld_addr < 5'(N_TOT));

  // Sign-extended difference exposes overflow in the top two bits.
  assign w_cur  = w_elem[r_idx];
  assign w_dsel = w_delta[r_idx];
  assign w_diff = {w_cur[WIDTH-1], w_cur} - {w_dsel[WIDTH-1], w_dsel};
  always_comb begin
    w_sat = w_diff[WIDTH-1:0];
    if (w_diff[WIDTH] != w_diff[WIDTH-1])
      w_sat = w_diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_last || w_fl) w_state_nxt = S_UPD;
      S_UPD:   if (r_idx == IW'(N_TOT - 1)) w_state_nxt = S_CLR;
      S_CLR:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_ready   = w_idle;
    o_done    = (r_state == S_CLR);
    o_acc_rst = (r_state == S_CLR);
  end

  assign o_acc_en = i_smpl_vld && w_idle;
  assign o_drop   = r_drop;

  always_ff @(posedge clk) begin
    if (rst)                    r_cnt <= '0;
    else if (w_go)              r_cnt <= '0;
    else if (w_idle && i_smpl_vld) r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)        r_idx <= '0;
    else if (w_upd) r_idx <= (r_idx == IW'(N_TOT - 1)) ? '0 : r_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                        r_drop <= 1'b0;
    else if (i_smpl_vld && !w_idle) r_drop <= 1'b1;
  end

  // Loads happen only in IDLE and updates only in UPD, so the write sources never collide.
  for (genvar k = 0; k < N_TOT; k++) begin : g_elem
    logic w_we;
    assign w_we = (w_ld && (i_ld_addr == 5'(k))) || (w_upd && (r_idx == IW'(k)));
    wbu_elem #(.WIDTH(WIDTH)) u_elem (
      .clk     (clk),
      .rst     (rst),
      .i_we    (w_we),
      .i_wdata (w_upd ? w_sat : i_ld_data),
      .o_q     (w_elem[k])
    );
  end

  assign o_bias_o  = w_elem[N_BO-1:0];
  assign o_bias_hd = w_elem[N_BO+N_BH-1:N_BO];
  assign o_wght_o  = w_elem[N_BO+N_BH+N_WO-1:N_BO+N_BH];
  assign o_wght_hd = w_elem[N_TOT-1:N_BO+N_BH+N_WO];
endmodule

// File: tb/tb_wght_bias_update.sv
// Directed bench for wght_bias_update: load, batch update, saturation, flush, drop and reset.
module tb_wght_bias_update;
  logic         clk = 1'b0;
  logic         rst, i_smpl_vld, i_flush, i_ld_en;
  logic [4:0]   i_ld_addr;
  logic [31:0]  i_ld_data;
  logic [543:0] d_all;
  logic         o_acc_en, o_acc_rst, o_ready, o_done, o_drop;
  logic [63:0]  o_bias_o;
  logic [95:0]  o_bias_hd;
  logic [191:0] o_wght_o;
  logic [191:0] o_wght_hd;
  int           n_chk = 0;
  int           n_err = 0;

  always #5 clk = ~clk;

  wght_bias_update dut (
    .clk(clk), .rst(rst), .i_smpl_vld(i_smpl_vld), .i_flush(i_flush),
    .i_ld_en(i_ld_en), .i_ld_addr(i_ld_addr), .i_ld_data(i_ld_data),
    .i_dbias_o(d_all[63:0]), .i_dbias_hd(d_all[159:64]),
    .i_dwght_o(d_all[351:160]), .i_dwght_hd(d_all[543:352]),
    .o_acc_en(o_acc_en), .o_acc_rst(o_acc_rst), .o_ready(o_ready), .o_done(o_done),
    .o_drop(o_drop), .o_bias_o(o_bias_o), .o_bias_hd(o_bias_hd),
    .o_wght_o(o_wght_o), .o_wght_hd(o_wght_hd)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [31:0] el(input int k);
    logic [543:0] a;
    a = {o_wght_hd, o_wght_o, o_bias_hd, o_bias_o};
    return a[k*32 +: 32];
  endfunction

  task automatic ld(input logic [4:0] a, input logic [31:0] v);
    i_ld_en = 1'b1; i_ld_addr = a; i_ld_data = v;
    tick();
    i_ld_en = 1'b0;
  endtask

  task automatic samples(input int n);
    for (int i = 0; i < n; i++) begin
      i_smpl_vld = 1'b1;
      tick();
    end
    i_smpl_vld = 1'b0;
  endtask

  // Counts cycles from now until o_done, bounded.
  task automatic wait_done(output int n);
    n = 0;
    while (!o_done && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic quiet(input string tag, input int cyc);
    int seen;
    seen = 0;
    for (int i = 0; i < cyc; i++) begin
      if (o_done || o_acc_rst || !o_ready) seen = 1;
      tick();
    end
    chk(tag, 64'(seen), 64'd0);
  endtask

  initial begin
    int n;
    rst = 1'b1; i_smpl_vld = 1'b0; i_flush = 1'b0; i_ld_en = 1'b0;
    i_ld_addr = '0; i_ld_data = '0; d_all = '0;
    #1;
    tick(); tick();
    rst = 1'b0;

    // reset state
    chk("rst_ready", 64'(o_ready), 64'd1);
    chk("rst_done", 64'(o_done), 64'd0);
    chk("rst_accrst", 64'(o_acc_rst), 64'd0);
    chk("rst_drop", 64'(o_drop), 64'd0);
    for (int k = 0; k < 17; k++) chk($sformatf("rst_e%0d", k), 64'(el(k)), 64'd0);

    // init loads, out-of-range address ignored
    ld(5'd5, 32'h0100_0000);
    ld(5'd16, 32'hFF80_0000);
    ld(5'd20, 32'd5);
    chk("ld_wo0", 64'(o_wght_o[31:0]), 64'h0100_0000);
    chk("ld_whtop", 64'(o_wght_hd[191:160]), 64'hFF80_0000);
    chk("ld_bo", 64'(o_bias_o), 64'd0);
    chk("ld_bh", 64'(o_bias_hd[63:0]), 64'd0);
    chk("ld_wo_rest", 64'(|o_wght_o[191:32]), 64'd0);
    chk("ld_wh_rest", 64'(|o_wght_hd[159:0]), 64'd0);

    // full batch with every delta 0x10
    for (int k = 0; k < 17; k++) d_all[k*32 +: 32] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      i_smpl_vld = 1'b1;
      #1 chk("b_acc_en", 64'(o_acc_en), 64'd1);
      tick();
    end
    i_smpl_vld = 1'b0;
    chk("b_upd_start", 64'(o_ready), 64'd0);
    wait_done(n);
    chk("b_lat", 64'(n), 64'd17);
    chk("b_accrst", 64'(o_acc_rst), 64'd1);
    tick();
    chk("b_done_1cyc", 64'(o_done), 64'd0);
    chk("b_accrst_1cyc", 64'(o_acc_rst), 64'd0);
    chk("b_ready", 64'(o_ready), 64'd1);
    chk("b_e0", 64'(el(0)), 64'hFFFF_FFF0);
    chk("b_e5", 64'(el(5)), 64'h00FF_FFF0);
    chk("b_e10", 64'(el(10)), 64'hFFFF_FFF0);
    chk("b_e16", 64'(el(16)), 64'hFF7F_FFF0);
    chk("b_drop", 64'(o_drop), 64'd0);

    // saturation both ways, partial batch + flush
    ld(5'd0, 32'h8000_0010);
    ld(5'd1, 32'h7FFF_FFF0);
    d_all = '0;
    d_all[31:0]  = 32'h7FFF_FFFF;
    d_all[63:32] = 32'h8000_0000;
    samples(2);
    chk("f_no_upd", 64'(o_ready), 64'd1);
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("f_upd_start", 64'(o_ready), 64'd0);
    wait_done(n);
    chk("f_lat", 64'(n), 64'd17);
    tick();
    chk("sat_neg", 64'(el(0)), 64'h8000_0000);
    chk("sat_pos", 64'(el(1)), 64'h7FFF_FFFF);
    chk("f_e5", 64'(el(5)), 64'h00FF_FFF0);

    // flush with empty batch does nothing
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    quiet("flush0_idle", 25);
    chk("flush0_e0", 64'(el(0)), 64'h8000_0000);

    // flush on the batch-closing sample: exactly one update
    d_all = '0;
    d_all[95:64] = 32'd1;
    samples(3);
    i_smpl_vld = 1'b1; i_flush = 1'b1;
    tick();
    i_smpl_vld = 1'b0; i_flush = 1'b0;
    wait_done(n);
    chk("fl_last_lat", 64'(n), 64'd17);
    tick();
    quiet("fl_last_once", 25);
    chk("fl_last_e2", 64'(el(2)), 64'hFFFF_FFEF);

    // sample while busy is dropped; reset mid-update aborts
    d_all = '0;
    samples(4);
    i_smpl_vld = 1'b1;
    #1 chk("d_acc_en", 64'(o_acc_en), 64'd0);
    tick();
    i_smpl_vld = 1'b0;
    chk("d_drop", 64'(o_drop), 64'd1);
    repeat (7) tick();
    chk("d_drop_sticky", 64'(o_drop), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("r_ready", 64'(o_ready), 64'd1);
    chk("r_drop", 64'(o_drop), 64'd0);
    chk("r_done", 64'(o_done), 64'd0);
    chk("r_e0", 64'(el(0)), 64'd0);
    chk("r_e5", 64'(el(5)), 64'd0);
    chk("r_e16", 64'(el(16)), 64'd0);
    quiet("r_no_done", 25);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
